rgb_led_ctrl: RTL and testbench

//  Drives the four RGB LEDs (LD0-LD3) and the four green LEDs (LD4-LD7) from the board buttons and switches.

---
 rtl/rgb_led_ctrl.sv | 134 +++++++++++++
 tb/tb_rgb_led_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rgb_led_ctrl.sv
// rgb_led_ctrl: button-stepped colours and switch-set PWM brightness for four
// RGB LEDs, plus debounced-button XOR switch on the four green LEDs.
module rgb_led_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PWM_BITS        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] sw,
  output logic [3:0] led,
  output logic [3:0] rgb_r,
  output logic [3:0] rgb_g,
  output logic [3:0] rgb_b
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned N_LED   = 4;
  localparam int unsigned LEVEL_W = 4;

  // Two-flop synchronisers
  logic [3:0] btn_m_q, btn_m_d, btn_s_q, btn_s_d;
  logic [3:0] sw_m_q,  sw_m_d,  sw_s_q,  sw_s_d;

  // Debounce state and edge detect
  logic [CNT_W-1:0] db_cnt_q [N_LED];
  logic [CNT_W-1:0] db_cnt_d [N_LED];
  logic [3:0]       btn_db_q, btn_db_d;
  logic [3:0]       btn_prev_q, btn_prev_d;

  // Per-LED colour, {r,g,b}
  logic [2:0] color_q [N_LED];
  logic [2:0] color_d [N_LED];

  // PWM counter and per-period duty latch
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LEVEL_W-1:0]  duty_q, duty_d;
  logic                pwm_on;

  // Registered outputs
  logic [3:0] led_q, led_d;
  logic [3:0] rgb_r_q, rgb_r_d;
  logic [3:0] rgb_g_q, rgb_g_d;
  logic [3:0] rgb_b_q, rgb_b_d;

  // Next-state logic for synchronisers, debounce, colour, PWM and outputs
  always_comb begin
    btn_m_d    = btn;
    btn_s_d    = btn_m_q;
    sw_m_d     = sw;
    sw_s_d     = sw_m_q;
    btn_db_d   = btn_db_q;
    btn_prev_d = btn_db_q;
    db_cnt_d   = db_cnt_q;
    color_d    = color_q;
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    duty_d     = duty_q;
    led_d      = btn_db_q ^ sw_s_q;
    rgb_r_d    = '0;
    rgb_g_d    = '0;
    rgb_b_d    = '0;

    // Duty only changes at the period boundary so a period never mixes levels
    if (pwm_cnt_q == '1) begin
      duty_d = sw_s_q;
    end
    pwm_on = (duty_q == 4'hF) || (pwm_cnt_q[PWM_BITS-1 -: LEVEL_W] < duty_q);

    for (int i = 0; i < int'(N_LED); i++) begin
      if (btn_s_q[i] == btn_db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d[i] = btn_s_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end

      if (btn_db_q[i] && !btn_prev_q[i]) begin
        color_d[i] = color_q[i] + 3'd1;
      end

      rgb_r_d[i] = pwm_on & color_q[i][2];
      rgb_g_d[i] = pwm_on & color_q[i][1];
      rgb_b_d[i] = pwm_on & color_q[i][0];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m_q    <= '0;
      btn_s_q    <= '0;
      sw_m_q     <= '0;
      sw_s_q     <= '0;
      btn_db_q   <= '0;
      btn_prev_q <= '0;
      for (int i = 0; i < int'(N_LED); i++) begin
        db_cnt_q[i] <= '0;
      end
      color_q[0] <= 3'b111;
      color_q[1] <= 3'b000;
      color_q[2] <= 3'b101;
      color_q[3] <= 3'b010;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      led_q      <= '0;
      rgb_r_q    <= '0;
      rgb_g_q    <= '0;
      rgb_b_q    <= '0;
    end else begin
      btn_m_q    <= btn_m_d;
      btn_s_q    <= btn_s_d;
      sw_m_q     <= sw_m_d;
      sw_s_q     <= sw_s_d;
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_prev_d;
      db_cnt_q   <= db_cnt_d;
      color_q    <= color_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      led_q      <= led_d;
      rgb_r_q    <= rgb_r_d;
      rgb_g_q    <= rgb_g_d;
      rgb_b_q    <= rgb_b_d;
    end
  end

  assign led   = led_q;
  assign rgb_r = rgb_r_q;
  assign rgb_g = rgb_g_q;
  assign rgb_b = rgb_b_q;

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Directed bench for rgb_led_ctrl with DEBOUNCE_CYCLES=4, PWM_BITS=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rgb_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] sw;
  logic [3:0] led, rgb_r, rgb_g, rgb_b;

  int n_vec = 0;
  int n_err = 0;

  rgb_led_ctrl #(.DEBOUNCE_CYCLES(4), .PWM_BITS(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .sw    (sw),
    .led   (led),
    .rgb_r (rgb_r),
    .rgb_g (rgb_g),
    .rgb_b (rgb_b)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] sw_val);
    rst = 1'b1;
    btn = 4'h0;
    sw  = sw_val;
    step(3);
    rst = 1'b0;
  endtask

  // Count cycles a given output bit is high over 256 samples
  task automatic count_high(input int which, output int cnt);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step(1);
      if (which == 0 && rgb_r[0]) cnt++;
      if (which == 1 && rgb_g[3]) cnt++;
    end
  endtask

  initial begin
    int c;
    rst = 1'b1;
    btn = 4'h0;
    sw  = 4'hF;
    step(1);

    // 1. Reset, full brightness, default colours
    step(2);
    chk("rst_rgb_r", 32'(rgb_r), 32'h0);
    chk("rst_rgb_g", 32'(rgb_g), 32'h0);
    chk("rst_rgb_b", 32'(rgb_b), 32'h0);
    chk("rst_led",   32'(led),   32'h0);
    rst = 1'b0;
    step(300);
    chk("def_rgb_r", 32'(rgb_r), 32'h5);
    chk("def_rgb_g", 32'(rgb_g), 32'h9);
    chk("def_rgb_b", 32'(rgb_b), 32'h5);
    chk("def_led",   32'(led),   32'hF);

    // 2. Single press on btn[1]: step 000->001 seven cycles after pin edge
    btn = 4'b0010;
    step(7);
    chk("b1_pre_b",  32'(rgb_b), 32'h5);
    step(1);
    chk("b1_post_b", 32'(rgb_b), 32'h7);
    chk("b1_led",    32'(led),   32'hD);
    step(20);
    chk("b1_hold_b", 32'(rgb_b), 32'h7);
    btn = 4'b0000;
    step(10);
    chk("b1_rel_b",  32'(rgb_b), 32'h7);
    chk("b1_rel_led", 32'(led),  32'hF);

    // 3. Bouncing btn[0], then held: single wrap 111->000
    btn = 4'b0001;
    step(2);
    btn = 4'b0000;
    step(2);
    btn = 4'b0001;
    step(2);
    chk("b0_bounce_r", 32'(rgb_r), 32'h5);
    step(10);
    chk("b0_wrap_r", 32'(rgb_r), 32'h4);
    chk("b0_wrap_g", 32'(rgb_g), 32'h8);
    chk("b0_wrap_b", 32'(rgb_b), 32'h6);
    btn = 4'b0000;
    step(10);

    // 4. Brightness: first period dark, then 4/16, 0, 8/16
    do_reset(4'h4);
    count_high(0, c);
    chk("pwm_first_period", 32'(c), 32'd0);
    step(100);
    count_high(0, c);
    chk("pwm_l4_r0", 32'(c), 32'd64);
    count_high(1, c);
    chk("pwm_l4_g3", 32'(c), 32'd64);
    sw = 4'h0;
    step(300);
    count_high(0, c);
    chk("pwm_l0_r0", 32'(c), 32'd0);
    sw = 4'h8;
    step(300);
    count_high(0, c);
    chk("pwm_l8_r0", 32'(c), 32'd128);

    // 5. All four buttons pressed together
    do_reset(4'hF);
    step(300);
    btn = 4'hF;
    step(7);
    chk("all_pre_r",  32'(rgb_r), 32'h5);
    step(1);
    chk("all_post_r", 32'(rgb_r), 32'h4);
    chk("all_post_g", 32'(rgb_g), 32'hC);
    chk("all_post_b", 32'(rgb_b), 32'hA);
    chk("all_led",    32'(led),   32'h0);
    btn = 4'h0;
    step(10);

    // 6. Reset in the middle of a btn[2] debounce
    btn = 4'b0100;
    step(4);
    rst = 1'b1;
    btn = 4'b0000;
    step(3);
    chk("mid_rst_r", 32'(rgb_r), 32'h0);
    chk("mid_rst_led", 32'(led), 32'h0);
    rst = 1'b0;
    step(300);
    chk("mid_def_r", 32'(rgb_r), 32'h5);
    chk("mid_def_b", 32'(rgb_b), 32'h5);
    btn = 4'b0100;
    step(6);
    chk("b2_early6_b", 32'(rgb_b), 32'h5);
    step(1);
    chk("b2_early7_b", 32'(rgb_b), 32'h5);
    step(1);
    chk("b2_step_g", 32'(rgb_g), 32'hD);
    chk("b2_step_b", 32'(rgb_b), 32'h1);
    chk("b2_led",    32'(led),   32'hB);
    btn = 4'b0000;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
